// File: rtl/maxnet_feeder.sv
// rtl/maxnet_feeder.sv - packs streamed activations into a vector, launches maxnet, returns its result
//
// Optional feature macro: MAXNET_FEEDER_CLAMP_EN (negative samples are stored as 0).
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   in_valid    sample offered
//   in_ready    sample accepted when in_valid & in_ready (FILL only)
//   in_data     sample value, two's complement
//   vec         packed activations, slot k at [k*WIDTH +: WIDTH]
//   mn_start    one-cycle launch pulse to maxnet
//   mn_done     maxnet completion, honoured only in WAIT
//   mn_result   maxnet result
//   out_valid   result available (OUT)
//   out_ready   downstream accepts
//   out_result  captured result, 0 on watchdog expiry
//   out_err     1 = watchdog expired
//   busy        high in any state except FILL
module maxnet_feeder #(
  parameter int NUM     = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic [NUM*WIDTH-1:0] vec,
  output logic                 mn_start,
  input  logic                 mn_done,
  input  logic [4:0]           mn_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_result,
  output logic                 out_err,
  output logic                 busy
);

  localparam int CW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM*WIDTH-1:0]   vec_q, vec_d;
  logic [TW-1:0]          wd_q, wd_d;
  logic [4:0]             out_result_q, out_result_d;
  logic                   out_err_q, out_err_d;
  logic [WIDTH-1:0]       sample;

  // maxnet only works on non-negative activations; the clamp build
  // replaces negative samples with zero before they reach the vector.
  always_comb begin
    sample = in_data;
`ifdef MAXNET_FEEDER_CLAMP_EN
    if (in_data[WIDTH-1]) begin
      sample = '0;
    end
`else
    sample = in_data;
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vec_d        = vec_q;
    wd_d         = wd_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;

    unique case (state_q)
      S_FILL: begin
        if (in_valid) begin
          for (int k = 0; k < NUM; k++) begin
            if (cnt_q == CW'(k)) begin
              vec_d[k*WIDTH +: WIDTH] = sample;
            end
          end
          if (cnt_q == CW'(NUM-1)) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_START: begin
        // mn_done is deliberately not looked at here: a level left over
        // from the previous run must not end this one.
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        // Completion takes priority over a watchdog expiring on the same edge.
        if (mn_done) begin
          out_result_d = mn_result;
          out_err_d    = 1'b0;
          state_d      = S_OUT;
        end else if (wd_q == TW'(TIMEOUT-1)) begin
          out_result_d = '0;
          out_err_d    = 1'b1;
          state_d      = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FILL;
      cnt_q        <= '0;
      vec_q        <= '0;
      wd_q         <= '0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vec_q        <= vec_d;
      wd_q         <= wd_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
    end
  end

  // Handshake and control outputs come from the state register alone.
  assign in_ready   = (state_q == S_FILL);
  assign mn_start   = (state_q == S_START);
  assign out_valid  = (state_q == S_OUT);
  assign busy       = (state_q != S_FILL);
  assign vec        = vec_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;

endmodule
